// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: cache line fill controller with optional dirty-victim write-back before the fill
module cache_fill_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic miss,
  input  logic dirty,
  input  logic [WORD_SIZE-1:0] miss_addr,
  input  logic [WORD_SIZE-1:0] victim_addr,
  input  logic [WORD_SIZE-1:0] victim_word,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_o,
  output logic line_valid,
  output logic busy
);
  localparam int LB = $clog2(WORDS_PER_LINE);
  localparam logic [WORD_SIZE-1:0] LO_MASK = {{(WORD_SIZE-LB-2){1'b0}}, {(LB+2){1'b1}}};
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  state_t state;
  logic [WORD_SIZE-1:0] fill_base;
  logic [WORD_SIZE-1:0] wb_base;
  assign mem_req = state == WB || state == FILL;
  assign mem_we = state == WB;
  assign busy = state != IDLE;
  assign line_valid = state == DONE;
  assign mem_wdata = victim_word;
  assign mem_addr = ((mem_we ? wb_base : fill_base) & ~LO_MASK) | {{(WORD_SIZE-LB-2){1'b0}}, word_idx, 2'b00};
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      word_idx <= '0;
      fill_base <= '0;
      wb_base <= '0;
      line_o <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          fill_base <= miss_addr;
          wb_base <= victim_addr;
          word_idx <= '0;
          state <= dirty ? WB : FILL;
        end
        WB, FILL: if (mem_ack) begin
          if (state == FILL) line_o[word_idx*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
          word_idx <= word_idx + LB'(1);
          if (&word_idx) state <= state == WB ? FILL : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed and randomized checks of cache_fill_ctrl against a transfer-queue model
module tb_cache_fill_ctrl;
  localparam int W = 32;
  localparam int N = 8;
  logic clk = 0;
  logic clr, miss, dirty, mem_ack;
  logic [W-1:0] miss_addr, victim_addr, victim_word, mem_rdata, rnd_rdata, mem_addr, mem_wdata;
  logic mem_req, mem_we, line_valid, busy;
  logic [2:0] word_idx;
  logic [W*N-1:0] line_o;
  logic [W-1:0] vbase = 32'hC0DE_0000;
  bit rd_from_idx = 1;
  bit chk_on = 0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign victim_word = vbase + W'(word_idx);
  assign mem_rdata = rd_from_idx ? 32'hA0 + W'(word_idx) : rnd_rdata;

  cache_fill_ctrl #(.WORD_SIZE(W), .WORDS_PER_LINE(N)) dut (
    .clk(clk), .clr(clr), .miss(miss), .dirty(dirty),
    .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_word(victim_word),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_idx(word_idx), .line_o(line_o),
    .line_valid(line_valid), .busy(busy)
  );

  function automatic void chk(string name, logic [W*N-1:0] act, logic [W*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic we; logic [W-1:0] addr; logic [2:0] idx;} xfer_t;
  xfer_t q[$];
  logic [W-1:0] m_line [N];
  bit m_done = 0;

  always @(posedge clk) begin
    if (clr) begin
      q.delete();
      m_done = 0;
      for (int i = 0; i < N; i++) m_line[i] = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (q.size() == 0) begin
      if (miss) begin
        if (dirty)
          for (int k = 0; k < N; k++) q.push_back({1'b1, (victim_addr / (4*N)) * (4*N) + W'(4*k), 3'(k)});
        for (int k = 0; k < N; k++) q.push_back({1'b0, (miss_addr / (4*N)) * (4*N) + W'(4*k), 3'(k)});
      end
    end else if (mem_ack) begin
      if (!q[0].we) m_line[q[0].idx] = mem_rdata;
      void'(q.pop_front());
      if (q.size() == 0) m_done = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [W*N-1:0] exp_line;
      logic req;
      for (int k = 0; k < N; k++) exp_line[k*W +: W] = m_line[k];
      req = q.size() != 0;
      chk("mem_req", W*N'(mem_req), W*N'(req));
      chk("mem_we", W*N'(mem_we), W*N'(req && q[0].we));
      chk("word_idx", W*N'(word_idx), W*N'(req ? q[0].idx : 3'd0));
      chk("line_valid", W*N'(line_valid), W*N'(m_done));
      chk("busy", W*N'(busy), W*N'(req || m_done));
      chk("line_o", line_o, exp_line);
      if (req) begin
        chk("mem_addr", W*N'(mem_addr), W*N'(q[0].addr));
        if (q[0].we) chk("mem_wdata", W*N'(mem_wdata), W*N'(vbase + W'(q[0].idx)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic d, input logic [W-1:0] ma, input logic [W-1:0] va, input logic ack);
    miss = 1;
    dirty = d;
    miss_addr = ma;
    victim_addr = va;
    mem_ack = ack;
  endtask

  task automatic run_line(input logic d, input logic [W-1:0] ma, input logic [W-1:0] va, input int per, input int exp_lat);
    int n = 0;
    int cyc = 0;
    bit done = 0;
    start(d, ma, va, per == 1);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (line_valid) done = 1;
      else begin
        tick();
        miss = 0;
        cyc++;
        mem_ack = (cyc % per) == 0;
      end
    end
    chk("line_valid_seen", W*N'(done), W*N'(1));
    if (exp_lat > 0) chk("latency", W*N'(n), W*N'(exp_lat));
    for (int k = 0; k < N; k++) chk("line_word", W*N'(line_o[k*W +: W]), W*N'(32'hA0 + k));
    tick();
    mem_ack = 0;
    tick();
  endtask

  initial begin
    clr = 1;
    miss = 0;
    dirty = 0;
    mem_ack = 0;
    miss_addr = '0;
    victim_addr = '0;
    rnd_rdata = '0;
    tick();
    tick();
    chk_on = 1;
    chk("reset_busy", W*N'(busy), '0);
    chk("reset_line", line_o, '0);
    clr = 0;
    tick();
    run_line(0, 32'h0000_1234, 32'h0, 1, N + 2);
    run_line(1, 32'h0000_1200, 32'h0000_4010, 1, 2*N + 2);
    run_line(0, 32'h0000_1234, 32'h0, 3, 0);
    run_line(1, 32'h0000_5678, 32'h0000_9ABC, 3, 0);
    start(0, 32'h0000_2000, 32'h0, 1);
    repeat (4) tick();
    miss = 0;
    clr = 1;
    tick();
    chk("midfill_busy", W*N'(busy), '0);
    chk("midfill_req", W*N'(mem_req), '0);
    chk("midfill_idx", W*N'(word_idx), '0);
    chk("midfill_line", line_o, '0);
    clr = 0;
    mem_ack = 0;
    tick();
    run_line(0, 32'h0000_3000, 32'h0, 1, N + 2);
    start(0, 32'h0000_3300, 32'h0, 1);
    repeat (N) tick();
    miss = 0;
    clr = 1;
    tick();
    chk("lastack_clr_lv", W*N'(line_valid), '0);
    chk("lastack_clr_busy", W*N'(busy), '0);
    clr = 0;
    mem_ack = 0;
    tick();
    rd_from_idx = 0;
    vbase = $urandom;
    for (int i = 0; i < 4000; i++) begin
      clr = $urandom_range(0, 199) == 0;
      miss = $urandom_range(0, 3) == 0;
      dirty = $urandom_range(0, 1) == 1;
      miss_addr = $urandom;
      victim_addr = $urandom;
      mem_ack = $urandom_range(0, 1) == 1;
      rnd_rdata = $urandom;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
